// File: rtl/core_ex_lsu_ctrl_if.sv
// Data-memory bus between the LSU sequencer (master) and the memory system (slave).
// One request channel with a ready handshake, one single-cycle response channel.
interface core_ex_lsu_ctrl_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;
    logic            mem_resp_err;

    modport master (
        output mem_req_valid,
        output mem_addr,
        output mem_we,
        output mem_wmask,
        output mem_wdata,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        input  mem_resp_err
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        input  mem_we,
        input  mem_wmask,
        input  mem_wdata,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        output mem_resp_err
    );
endinterface

// File: rtl/core_ex_lsu_ctrl.sv
// Single-outstanding load/store sequencer between EX and the data-memory bus:
// alignment check, lane steering, response timeout and load extension for writeback.
module core_ex_lsu_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [XLEN-1:0]    ex_addr,
    input  logic [XLEN-1:0]    ex_wdata,
    input  logic               ex_store,
    input  logic [1:0]         ex_size,
    input  logic               ex_unsigned,
    input  logic [4:0]         ex_rd,
    core_ex_lsu_ctrl_if.master mem,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [XLEN-1:0]    wb_rdata,
    output logic [4:0]         wb_rd,
    output logic [1:0]         wb_exc
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic            store_q, unsigned_q;
    logic [1:0]      size_q;
    logic [4:0]      rd_q;
    logic            kill_q, kill_d;
    logic [7:0]      timer_q, timer_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [1:0]      exc_q, exc_d;

    logic            accept, misaligned;
    logic            req_active, resp_active;
    logic [1:0]      offset;
    logic [3:0]      lane_mask;
    logic [XLEN-1:0] lane_data, load_data;

    // Outputs are forced low while rst is held, so nothing leaks from a stale state.
    assign offset      = addr_q[1:0];
    assign ex_ready    = ~rst & (state_q == IDLE) & ~flush;
    assign accept      = ex_valid & ex_ready;
    assign req_active  = ~rst & (state_q == REQ);
    assign resp_active = ~rst & (state_q == RESP);

    assign mem.mem_req_valid = req_active;
    assign mem.mem_addr      = req_active ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem.mem_we        = req_active & store_q;
    assign mem.mem_wmask     = (req_active & store_q) ? lane_mask : 4'b0000;
    assign mem.mem_wdata     = req_active ? (wdata_q << {offset, 3'b000}) : '0;

    assign wb_valid = resp_active & ~flush;
    assign wb_rdata = resp_active ? rdata_q : '0;
    assign wb_rd    = resp_active ? rd_q : 5'd0;
    assign wb_exc   = resp_active ? exc_q : 2'b00;

    always_comb begin
        unique case (ex_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_addr[0];
            2'b10:   misaligned = |ex_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Lane mask for stores and right-justified, extended data for loads.
    always_comb begin
        lane_data = mem.mem_resp_data >> {offset, 3'b000};
        unique case (size_q)
            2'b00: begin
                lane_mask = 4'b0001 << offset;
                load_data = {{(XLEN-8){~unsigned_q & lane_data[7]}}, lane_data[7:0]};
            end
            2'b01: begin
                lane_mask = 4'b0011 << offset;
                load_data = {{(XLEN-16){~unsigned_q & lane_data[15]}}, lane_data[15:0]};
            end
            default: begin
                lane_mask = 4'b1111;
                load_data = lane_data;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        unique case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (accept) begin
                    if (misaligned) begin
                        state_d = RESP;
                        exc_d   = 2'b01;
                        rdata_d = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) kill_d = 1'b1;
                if (mem.mem_req_ready) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                if (flush) kill_d = 1'b1;
                timer_d = timer_q + 8'd1;
                // A killed op still drains its response, it just never reaches writeback.
                if (mem.mem_resp_valid) begin
                    state_d = (kill_q | flush) ? IDLE : RESP;
                    exc_d   = mem.mem_resp_err ? 2'b10 : 2'b00;
                    rdata_d = (mem.mem_resp_err | store_q) ? '0 : load_data;
                end else if (timer_q + 8'd1 == TIMEOUT_CNT) begin
                    state_d = (kill_q | flush) ? IDLE : RESP;
                    exc_d   = 2'b11;
                    rdata_d = '0;
                end
            end
            default: begin
                if (flush | wb_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            kill_q     <= 1'b0;
            timer_q    <= '0;
            rdata_q    <= '0;
            exc_q      <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            rd_q       <= 5'd0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            if (accept) begin
                addr_q     <= ex_addr;
                wdata_q    <= ex_wdata;
                store_q    <= ex_store;
                size_q     <= ex_size;
                unsigned_q <= ex_unsigned;
                rd_q       <= ex_rd;
            end
        end
    end
endmodule

// File: tb/tb_core_ex_lsu_ctrl.sv
// Self-checking bench for core_ex_lsu_ctrl: directed vector table, hand-written
// flush/reset sequences and randomized ops checked against a behavioural model.
module tb_core_ex_lsu_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, ex_store, ex_unsigned, wb_ready;
    logic [31:0] ex_addr, ex_wdata;
    logic [1:0]  ex_size;
    logic [4:0]  ex_rd;
    logic        ex_ready, wb_valid;
    logic [31:0] wb_rdata;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_exc;

    always #5 clk = ~clk;

    core_ex_lsu_ctrl_if #(.XLEN(32)) mem_bus ();

    core_ex_lsu_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_store(ex_store), .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_rd(ex_rd),
        .mem(mem_bus),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdata(wb_rdata), .wb_rd(wb_rd), .wb_exc(wb_exc)
    );

    typedef struct {
        logic [31:0] addr, wdata;
        logic        store;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        int          stall, delay;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        fault;
        logic [31:0] mem_addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
        logic [1:0]  exc;
        int          lat;
    } exp_t;

    typedef struct {
        logic        acc_ready;
        int          req_cnt;
        logic        stable;
        logic [31:0] mem_addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  exc;
        int          lat;
        logic        ready_after;
    } obs_t;

    typedef struct {
        vec_t v;
        exp_t e;
    } row_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_err   = 1'b0;
        mem_bus.mem_resp_data  = '0;
    endtask

    function automatic vec_t mk_vec(input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic store, input logic [1:0] size, input logic uns,
                                    input logic [4:0] rd, input int stall, input int delay,
                                    input logic [31:0] rdata, input logic err);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.store = store; v.size = size; v.uns = uns;
        v.rd = rd; v.stall = stall; v.delay = delay; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    function automatic exp_t mk_exp(input logic fault, input logic [31:0] mem_addr,
                                    input logic [3:0] wmask, input logic [31:0] wdata,
                                    input logic we, input logic [31:0] rdata,
                                    input logic [1:0] exc, input int lat);
        exp_t e;
        e.fault = fault; e.mem_addr = mem_addr; e.wmask = wmask; e.wdata = wdata;
        e.we = we; e.rdata = rdata; e.exc = exc; e.lat = lat;
        return e;
    endfunction

    // Reference: an access is legal when the address is a multiple of its byte count.
    function automatic exp_t ref_model(input vec_t v);
        exp_t   e;
        int     off, nbytes;
        longint val, span;
        off    = int'(v.addr % 4);
        nbytes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        e = mk_exp(1'b0, '0, 4'b0000, '0, 1'b0, '0, 2'b00, 0);
        if (v.size == 2'd3 || (v.addr % nbytes) != 0) begin
            e.fault = 1'b1;
            e.exc   = 2'b01;
            e.lat   = 1;
            return e;
        end
        e.mem_addr = v.addr - 32'(off);
        e.we       = v.store;
        e.wmask    = v.store ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;
        e.wdata    = 32'(64'(v.wdata) << (8 * off));
        if (v.delay < TO) begin
            e.exc = v.err ? 2'b10 : 2'b00;
            e.lat = 3 + v.stall + v.delay;
        end else begin
            e.exc = 2'b11;
            e.lat = 2 + v.stall + TO;
        end
        if (e.exc == 2'b00 && !v.store) begin
            span = longint'(1) << (8 * nbytes);
            val  = (longint'(v.rdata) >> (8 * off)) % span;
            if (!v.uns && nbytes < 4 && val >= span / 2) val = val - span;
            e.rdata = 32'(val);
        end
        return e;
    endfunction

    // Drives one op from EX, plays a bus with the requested stall/delay, records what the DUT did.
    task automatic apply_stimulus(input vec_t v, output obs_t o);
        int           req_cnt = 0;
        int           wait_idx = 0;
        bit           waiting = 0;
        bit           done = 0;
        logic [68:0]  first_bus = '0;
        logic [68:0]  cur_bus;
        o.acc_ready = 1'b0; o.req_cnt = 0; o.stable = 1'b1; o.mem_addr = '0; o.wmask = '0;
        o.wdata = '0; o.we = 1'b0; o.rdata = '0; o.rd = '0; o.exc = '0; o.lat = -1; o.ready_after = 1'b0;
        ex_valid = 1'b1; ex_addr = v.addr; ex_wdata = v.wdata; ex_store = v.store;
        ex_size = v.size; ex_unsigned = v.uns; ex_rd = v.rd; wb_ready = 1'b1;
        #1;
        o.acc_ready = ex_ready;
        tick();
        ex_valid = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            clear_bus();
            if (mem_bus.mem_req_valid) begin
                cur_bus = {mem_bus.mem_addr, mem_bus.mem_wmask, mem_bus.mem_wdata, mem_bus.mem_we};
                if (req_cnt == 0) begin
                    first_bus  = cur_bus;
                    o.mem_addr = mem_bus.mem_addr;
                    o.wmask    = mem_bus.mem_wmask;
                    o.wdata    = mem_bus.mem_wdata;
                    o.we       = mem_bus.mem_we;
                end else if (cur_bus !== first_bus) begin
                    o.stable = 1'b0;
                end
                if (req_cnt == v.stall) begin
                    mem_bus.mem_req_ready = 1'b1;
                    waiting = 1;
                end
                req_cnt++;
            end else if (waiting) begin
                if (wait_idx == v.delay) begin
                    mem_bus.mem_resp_valid = 1'b1;
                    mem_bus.mem_resp_data  = v.rdata;
                    mem_bus.mem_resp_err   = v.err;
                    waiting = 0;
                end
                wait_idx++;
            end
            if (wb_valid) begin
                o.rdata = wb_rdata;
                o.rd    = wb_rd;
                o.exc   = wb_exc;
                o.lat   = c;
                done    = 1;
            end
            tick();
        end
        clear_bus();
        o.req_cnt = req_cnt;
        #1;
        o.ready_after = ex_ready;
    endtask

    task automatic check_output(input string tag, input vec_t v, input exp_t e, input obs_t o);
        check({tag, ".accept_ready"}, 32'(o.acc_ready), 32'd1);
        check({tag, ".wb_exc"}, 32'(o.exc), 32'(e.exc));
        check({tag, ".wb_rdata"}, o.rdata, e.rdata);
        check({tag, ".wb_rd"}, 32'(o.rd), 32'(v.rd));
        check({tag, ".latency"}, 32'(o.lat), 32'(e.lat));
        check({tag, ".ready_after"}, 32'(o.ready_after), 32'd1);
        if (e.fault) begin
            check({tag, ".req_cycles"}, 32'(o.req_cnt), 32'd0);
        end else begin
            check({tag, ".req_cycles"}, 32'(o.req_cnt), 32'(v.stall + 1));
            check({tag, ".mem_addr"}, o.mem_addr, e.mem_addr);
            check({tag, ".mem_wmask"}, 32'(o.wmask), 32'(e.wmask));
            check({tag, ".mem_wdata"}, o.wdata, e.wdata);
            check({tag, ".mem_we"}, 32'(o.we), 32'(e.we));
            check({tag, ".req_stable"}, 32'(o.stable), 32'd1);
        end
    endtask

    task automatic stray_response();
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_err   = 1'b1;
        mem_bus.mem_resp_data  = 32'hFFFF_FFFF;
        #1;
        check("stray.ex_ready", 32'(ex_ready), 32'd1);
        tick();
        clear_bus();
        #1;
        check("stray.wb_valid", 32'(wb_valid), 32'd0);
        check("stray.ex_ready_next", 32'(ex_ready), 32'd1);
    endtask

    task automatic start_word_load(input logic [31:0] addr, input logic ready);
        ex_valid = 1'b1; ex_addr = addr; ex_wdata = '0; ex_store = 1'b0;
        ex_size = 2'b10; ex_unsigned = 1'b0; ex_rd = 5'd3; wb_ready = ready;
        tick();
        ex_valid = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        tick();
        mem_bus.mem_req_ready = 1'b0;
    endtask

    task automatic flush_in_wait();
        start_word_load(32'h0000_A000, 1'b1);
        flush = 1'b1;
        #1;
        check("fw.ex_ready_flush", 32'(ex_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fw.wb_valid_wait", 32'(wb_valid), 32'd0);
        tick();
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = 32'h1122_3344;
        #1;
        check("fw.wb_valid_resp", 32'(wb_valid), 32'd0);
        tick();
        clear_bus();
        #1;
        check("fw.wb_valid_after", 32'(wb_valid), 32'd0);
        check("fw.ex_ready_after", 32'(ex_ready), 32'd1);
    endtask

    task automatic flush_in_resp();
        start_word_load(32'h0000_B000, 1'b0);
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = 32'h0000_0055;
        tick();
        clear_bus();
        #1;
        check("fr.wb_valid", 32'(wb_valid), 32'd1);
        check("fr.wb_rdata", wb_rdata, 32'h0000_0055);
        tick();
        check("fr.wb_valid_held", 32'(wb_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("fr.wb_valid_dropped", 32'(wb_valid), 32'd0);
        check("fr.ex_ready", 32'(ex_ready), 32'd1);
        wb_ready = 1'b1;
    endtask

    task automatic reset_mid_op();
        start_word_load(32'h0000_C000, 1'b1);
        rst = 1'b1;
        #1;
        check("rm.ex_ready_in_rst", 32'(ex_ready), 32'd0);
        check("rm.req_valid_in_rst", 32'(mem_bus.mem_req_valid), 32'd0);
        tick();
        rst = 1'b0;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = 32'hDEAD_0000;
        #1;
        check("rm.ex_ready", 32'(ex_ready), 32'd1);
        tick();
        clear_bus();
        #1;
        check("rm.wb_valid", 32'(wb_valid), 32'd0);
        check("rm.ex_ready_next", 32'(ex_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        row_t rows[13];
        vec_t v;
        exp_t e;
        obs_t o;

        rows[0]  = '{mk_vec(32'h1003, 32'h0, 1'b0, 2'b00, 1'b0, 5'd5, 0, 0, 32'h80FF_1234, 1'b0),
                     mk_exp(1'b0, 32'h1000, 4'b0000, 32'h0, 1'b0, 32'hFFFF_FF80, 2'b00, 3)};
        rows[1]  = '{mk_vec(32'h2002, 32'h0000_ABCD, 1'b1, 2'b01, 1'b0, 5'd6, 0, 0, 32'hDEAD_BEEF, 1'b0),
                     mk_exp(1'b0, 32'h2000, 4'b1100, 32'hABCD_0000, 1'b1, 32'h0, 2'b00, 3)};
        rows[2]  = '{mk_vec(32'h3001, 32'h0, 1'b0, 2'b10, 1'b0, 5'd7, 0, 0, 32'h0, 1'b0),
                     mk_exp(1'b1, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 2'b01, 1)};
        rows[3]  = '{mk_vec(32'h3001, 32'h0, 1'b0, 2'b01, 1'b0, 5'd8, 0, 0, 32'h0, 1'b0),
                     mk_exp(1'b1, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 2'b01, 1)};
        rows[4]  = '{mk_vec(32'h3000, 32'h0, 1'b1, 2'b11, 1'b0, 5'd9, 0, 0, 32'h0, 1'b0),
                     mk_exp(1'b1, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h0, 2'b01, 1)};
        rows[5]  = '{mk_vec(32'h4000, 32'h0, 1'b0, 2'b10, 1'b0, 5'd10, 5, 0, 32'h1234_5678, 1'b1),
                     mk_exp(1'b0, 32'h4000, 4'b0000, 32'h0, 1'b0, 32'h0, 2'b10, 8)};
        rows[6]  = '{mk_vec(32'h5000, 32'h0, 1'b0, 2'b10, 1'b0, 5'd11, 0, 9, 32'h0, 1'b0),
                     mk_exp(1'b0, 32'h5000, 4'b0000, 32'h0, 1'b0, 32'h0, 2'b11, 6)};
        rows[7]  = '{mk_vec(32'h6002, 32'h0, 1'b0, 2'b01, 1'b1, 5'd12, 0, 0, 32'h8001_0000, 1'b0),
                     mk_exp(1'b0, 32'h6000, 4'b0000, 32'h0, 1'b0, 32'h0000_8001, 2'b00, 3)};
        rows[8]  = '{mk_vec(32'h6002, 32'h0, 1'b0, 2'b01, 1'b0, 5'd13, 0, 3, 32'h8001_0000, 1'b0),
                     mk_exp(1'b0, 32'h6000, 4'b0000, 32'h0, 1'b0, 32'hFFFF_8001, 2'b00, 6)};
        rows[9]  = '{mk_vec(32'h7001, 32'h1234_56AB, 1'b1, 2'b00, 1'b0, 5'd14, 2, 0, 32'h0, 1'b0),
                     mk_exp(1'b0, 32'h7000, 4'b0010, 32'h3456_AB00, 1'b1, 32'h0, 2'b00, 5)};
        rows[10] = '{mk_vec(32'h8000, 32'h0, 1'b0, 2'b00, 1'b1, 5'd15, 0, 1, 32'h0000_00F0, 1'b0),
                     mk_exp(1'b0, 32'h8000, 4'b0000, 32'h0, 1'b0, 32'h0000_00F0, 2'b00, 4)};
        rows[11] = '{mk_vec(32'h9000, 32'hCAFE_F00D, 1'b1, 2'b10, 1'b0, 5'd16, 0, 0, 32'h0, 1'b1),
                     mk_exp(1'b0, 32'h9000, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0, 2'b10, 3)};
        rows[12] = '{mk_vec(32'h7003, 32'h0000_00AB, 1'b1, 2'b00, 1'b0, 5'd17, 0, 4, 32'h0, 1'b0),
                     mk_exp(1'b0, 32'h7000, 4'b1000, 32'hAB00_0000, 1'b1, 32'h0, 2'b11, 6)};

        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_addr = '0; ex_wdata = '0; ex_store = 1'b0;
        ex_size = 2'b00; ex_unsigned = 1'b0; ex_rd = '0; wb_ready = 1'b1;
        clear_bus();
        tick();
        tick();
        #1;
        check("reset.ex_ready", 32'(ex_ready), 32'd0);
        check("reset.wb_valid", 32'(wb_valid), 32'd0);
        check("reset.req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_reset.ex_ready", 32'(ex_ready), 32'd1);
        check("post_reset.wb_valid", 32'(wb_valid), 32'd0);
        check("post_reset.req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
        check("post_reset.wb_exc", 32'(wb_exc), 32'd0);

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(rows[i].v, o);
            check_output($sformatf("row%0d", i), rows[i].v, rows[i].e, o);
            if (i == 6) stray_response();
        end

        flush_in_wait();
        flush_in_resp();
        reset_mid_op();

        for (int i = 0; i < 40; i++) begin
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.store = 1'($urandom_range(0, 1));
            v.size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            v.uns   = 1'($urandom_range(0, 1));
            v.rd    = 5'($urandom_range(0, 31));
            v.stall = $urandom_range(0, 3);
            v.delay = $urandom_range(0, 5);
            v.rdata = $urandom;
            v.err   = ($urandom_range(0, 7) == 0);
            e = ref_model(v);
            apply_stimulus(v, o);
            check_output($sformatf("rnd%0d", i), v, e, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
